// File: rtl/cpu_pkg.sv
// Shared types and codes for the multi-cycle processor control path.
package cpu_pkg;

  localparam logic [5:0] HALT_OP_DEF = 6'd32;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [2:0] BR_NONE   = 3'd0;
  localparam logic [2:0] BR_ALWAYS = 3'd1;
  localparam logic [2:0] BR_NEG    = 3'd2;
  localparam logic [2:0] BR_NNEG   = 3'd3;
  localparam logic [2:0] BR_ZERO   = 3'd4;

  localparam logic [2:0] ST_NONE = 3'd0;
  localparam logic [2:0] ST_SPLD = 3'd1;
  localparam logic [2:0] ST_POP  = 3'd2;
  localparam logic [2:0] ST_PUSH = 3'd3;
  localparam logic [2:0] ST_RET  = 3'd4;

endpackage

// File: rtl/multicycle_sequencer_branch_eval.sv
// Branch condition evaluation: branch code plus ALU flags -> taken.
module branch_eval
  import cpu_pkg::*;
(
  input  logic [2:0] br,
  input  logic       flag_z,
  input  logic       flag_n,
  output logic       taken
);

  assign taken = (br == BR_ALWAYS)
               | ((br == BR_NEG)  &  flag_n)
               | ((br == BR_NNEG) & ~flag_n)
               | ((br == BR_ZERO) &  flag_z);

endmodule

// File: rtl/multicycle_sequencer.sv
// Phase sequencer: walks FETCH/DECODE/EXEC/MEM/WB from the control-unit
// decode fields, drives datapath strobes and counts retired instructions.
//
// state    | meaning
// ---------+-------------------------------------------------------
// S_FETCH  | instruction read; IR and PC+1 load on mem_ready
// S_DECODE | halt / SP load / push pre-decrement
// S_EXEC   | ALU result latch, branch resolution
// S_MEM    | data access, held until mem_ready
// S_WB     | register / SP / return-PC writeback
// S_HALT   | parked, only rst leaves
module multicycle_sequencer
  import cpu_pkg::*;
#(
  parameter logic [5:0] HALT_OP = HALT_OP_DEF,
  parameter int         CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             memen,
  input  logic             memwr,
  input  logic [1:0]       wrreg,
  input  logic [2:0]       br,
  input  logic [2:0]       st,
  input  logic             flag_z,
  input  logic             flag_n,
  input  logic             mem_ready,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mdr_we,
  output logic             alu_we,
  output logic             rf_we,
  output logic             sp_we,
  output logic             sp_dec,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             rst_hold_q, rst_hold_d;
  logic             br_taken;
  logic             retire;

  branch_eval u_branch_eval (
    .br     (br),
    .flag_z (flag_z),
    .flag_n (flag_n),
    .taken  (br_taken)
  );

  always_comb begin
    state_d    = state_q;
    rst_hold_d = 1'b0;
    retire     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mdr_we     = 1'b0;
    alu_we     = 1'b0;
    rf_we      = 1'b0;
    sp_we      = 1'b0;
    sp_dec     = 1'b0;
    halted     = 1'b0;

    case (state_q)
      // The cycle right after a reset sample stays quiet so an abandoned
      // access is visibly dropped before the first fetch is issued.
      S_FETCH: begin
        if (!rst_hold_q) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        if (opcode == HALT_OP) begin
          state_d = S_HALT;
          retire  = 1'b1;
        end else if (st == ST_SPLD) begin
          sp_we   = 1'b1;
          state_d = S_FETCH;
          retire  = 1'b1;
        end else begin
          if (st == ST_PUSH) begin
            sp_we  = 1'b1;
            sp_dec = 1'b1;
          end
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_we = 1'b1;
        if (br != BR_NONE) begin
          pc_we   = br_taken;
          pc_src  = br_taken;
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (memen) begin
          state_d = S_MEM;
        end else if (wrreg != 2'd0) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = memwr;
        if (mem_ready) begin
          mdr_we = ~memwr;
          if (!memwr && ((wrreg != 2'd0) || (st == ST_RET))) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end
      end
      S_WB: begin
        rf_we = (wrreg != 2'd0);
        if ((st == ST_POP) || (st == ST_RET)) sp_we = 1'b1;
        if (st == ST_RET) begin
          pc_we  = 1'b1;
          pc_src = 1'b1;
        end
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      retired_q  <= '0;
      rst_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      retired_q  <= retired_d;
      rst_hold_q <= rst_hold_d;
    end
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench: per-cycle expected strobe vectors are queued with the
// mem_ready value for that cycle, then popped and compared as the DUT runs.
module tb_multicycle_sequencer;

  localparam logic [10:0] IR  = 11'h400;
  localparam logic [10:0] PC  = 11'h200;
  localparam logic [10:0] PS  = 11'h100;
  localparam logic [10:0] MR  = 11'h080;
  localparam logic [10:0] MW  = 11'h040;
  localparam logic [10:0] MD  = 11'h020;
  localparam logic [10:0] AL  = 11'h010;
  localparam logic [10:0] RF  = 11'h008;
  localparam logic [10:0] SP  = 11'h004;
  localparam logic [10:0] SD  = 11'h002;
  localparam logic [10:0] HL  = 11'h001;
  localparam logic [10:0] FETCH_OK = IR | PC | MR;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        memen, memwr;
  logic [1:0]  wrreg;
  logic [2:0]  br, st;
  logic        flag_z, flag_n, mem_ready;
  logic        ir_we, pc_we, pc_src, mem_req, mem_we, mdr_we, alu_we, rf_we;
  logic        sp_we, sp_dec, halted;
  logic [31:0] retired;
  logic [10:0] obs;

  int tests = 0;
  int fails = 0;

  logic [10:0] exp_q[$];
  bit          rdy_q[$];
  logic [10:0] e;
  int          cyc;

  always #5 clk = ~clk;

  multicycle_sequencer dut (
    .clk(clk), .rst(rst), .opcode(opcode), .memen(memen), .memwr(memwr),
    .wrreg(wrreg), .br(br), .st(st), .flag_z(flag_z), .flag_n(flag_n),
    .mem_ready(mem_ready), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .mem_req(mem_req), .mem_we(mem_we), .mdr_we(mdr_we), .alu_we(alu_we),
    .rf_we(rf_we), .sp_we(sp_we), .sp_dec(sp_dec), .halted(halted),
    .retired(retired)
  );

  assign obs = {ir_we, pc_we, pc_src, mem_req, mem_we, mdr_we, alu_we,
                rf_we, sp_we, sp_dec, halted};

  task automatic push(input logic [10:0] v, input bit r);
    exp_q.push_back(v);
    rdy_q.push_back(r);
  endtask

  task automatic set_instr(input logic [5:0] op, input logic me, input logic mw,
                           input logic [1:0] wr, input logic [2:0] b,
                           input logic [2:0] s, input logic z, input logic n);
    opcode = op; memen = me; memwr = mw; wrreg = wr; br = b; st = s;
    flag_z = z; flag_n = n;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_instr(6'd0, 1'b0, 1'b0, 2'd1, 3'd0, 3'd0, 1'b0, 1'b0);
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push(11'h000, 1'b1);
    push(FETCH_OK, 1'b1);
    push(11'h000, 1'b1);
    push(AL, 1'b1);
    push(RF, 1'b1);
    cyc = 0;
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL reset_alu cyc%0d: got %b want %b", cyc, obs, e);
      end
      if (cyc == 0) begin
        tests++;
        if (retired !== 32'd0) begin
          fails++;
          $display("FAIL reset_retired: got %0d want 0", retired);
        end
      end
      cyc++;
      @(posedge clk); #1;
    end
    tests++;
    if (retired !== 32'd1) begin
      fails++;
      $display("FAIL alu_retired: got %0d want 1", retired);
    end
  endtask

  task automatic test_load_wait;
    set_instr(6'd18, 1'b1, 1'b0, 2'd2, 3'd0, 3'd0, 1'b0, 1'b0);
    push(FETCH_OK, 1'b1);
    push(11'h000, 1'b1);
    push(AL, 1'b1);
    push(MR, 1'b0);
    push(MR, 1'b0);
    push(MR, 1'b0);
    push(MR | MD, 1'b1);
    push(RF, 1'b1);
    cyc = 0;
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL load_wait cyc%0d: got %b want %b", cyc, obs, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
    tests++;
    if (retired !== 32'd2) begin
      fails++;
      $display("FAIL load_retired: got %0d want 2", retired);
    end
  endtask

  task automatic test_branches;
    logic [2:0]  b_tab[4]  = '{3'd4, 3'd4, 3'd2, 3'd3};
    logic        z_tab[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        n_tab[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic        tk_tab[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      set_instr(6'd5, 1'b0, 1'b0, 2'd0, b_tab[k], 3'd0, z_tab[k], n_tab[k]);
      push(FETCH_OK, 1'b1);
      push(11'h000, 1'b1);
      push(tk_tab[k] ? (AL | PC | PS) : AL, 1'b1);
      cyc = 0;
      while (exp_q.size() > 0) begin
        mem_ready = rdy_q.pop_front();
        @(negedge clk);
        e = exp_q.pop_front();
        tests++;
        if (obs !== e) begin
          fails++;
          $display("FAIL branch%0d cyc%0d: got %b want %b", k, cyc, obs, e);
        end
        cyc++;
        @(posedge clk); #1;
      end
    end
    tests++;
    if (retired !== 32'd6) begin
      fails++;
      $display("FAIL branch_retired: got %0d want 6", retired);
    end
  endtask

  task automatic test_stack;
    // push
    set_instr(6'd40, 1'b1, 1'b1, 2'd0, 3'd0, 3'd3, 1'b0, 1'b0);
    push(FETCH_OK, 1'b1); push(SP | SD, 1'b1); push(AL, 1'b1); push(MR | MW, 1'b1);
    cyc = 0;
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL push cyc%0d: got %b want %b", cyc, obs, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
    // pop, return, SP load
    set_instr(6'd41, 1'b1, 1'b0, 2'd1, 3'd0, 3'd2, 1'b0, 1'b0);
    push(FETCH_OK, 1'b1); push(11'h000, 1'b1); push(AL, 1'b1);
    push(MR | MD, 1'b1); push(RF | SP, 1'b1);
    cyc = 0;
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL pop cyc%0d: got %b want %b", cyc, obs, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
    set_instr(6'd42, 1'b1, 1'b0, 2'd0, 3'd0, 3'd4, 1'b0, 1'b0);
    push(FETCH_OK, 1'b1); push(11'h000, 1'b1); push(AL, 1'b1);
    push(MR | MD, 1'b1); push(PC | PS | SP, 1'b1);
    cyc = 0;
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL return cyc%0d: got %b want %b", cyc, obs, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
    set_instr(6'd44, 1'b0, 1'b0, 2'd0, 3'd0, 3'd1, 1'b0, 1'b0);
    push(FETCH_OK, 1'b1); push(SP, 1'b1);
    cyc = 0;
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL spload cyc%0d: got %b want %b", cyc, obs, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
    tests++;
    if (retired !== 32'd10) begin
      fails++;
      $display("FAIL stack_retired: got %0d want 10", retired);
    end
  endtask

  task automatic test_back_to_back;
    // store with a fetch wait state, immediately followed by the halt test
    set_instr(6'd43, 1'b1, 1'b1, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    push(MR, 1'b0); push(FETCH_OK, 1'b1); push(11'h000, 1'b1);
    push(AL, 1'b1); push(MR | MW, 1'b1);
    cyc = 0;
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL store_fwait cyc%0d: got %b want %b", cyc, obs, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
    tests++;
    if (retired !== 32'd11) begin
      fails++;
      $display("FAIL store_retired: got %0d want 11", retired);
    end
  endtask

  task automatic test_halt;
    set_instr(6'd32, 1'b1, 1'b0, 2'd1, 3'd1, 3'd2, 1'b1, 1'b1);
    push(FETCH_OK, 1'b1);
    push(11'h000, 1'b1);
    for (int i = 0; i < 20; i++) push(HL, i[0]);
    cyc = 0;
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL halt cyc%0d: got %b want %b", cyc, obs, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
    tests++;
    if (retired !== 32'd12) begin
      fails++;
      $display("FAIL halt_retired: got %0d want 12", retired);
    end
  endtask

  task automatic test_reset_mid_mem;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    set_instr(6'd43, 1'b1, 1'b1, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    push(11'h000, 1'b1); push(FETCH_OK, 1'b1); push(11'h000, 1'b1);
    push(AL, 1'b1); push(MR | MW, 1'b0); push(MR | MW, 1'b0);
    cyc = 0;
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL rst_mem_pre cyc%0d: got %b want %b", cyc, obs, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if (obs !== 11'h000 || retired !== 32'd0) begin
      fails++;
      $display("FAIL rst_mid_mem: got %b/%0d want %b/0", obs, retired, 11'h000);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (obs !== MR) begin
      fails++;
      $display("FAIL rst_refetch: got %b want %b", obs, MR);
    end
  endtask

  initial begin
    test_reset();
    test_load_wait();
    test_branches();
    test_stack();
    test_back_to_back();
    test_halt();
    test_reset_mid_mem();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Phase sequencer for the multi-cycle processor. It sits directly downstream of the control unit and consumes that unit's static decode fields: opcode, memen, memwr, wrreg, br and st. From these it drives the per-cycle datapath enables through the FETCH/DECODE/EXEC/MEM/WB phases, honouring memory wait states, branch conditions and stack sequencing. It also counts retired instructions.

## Interface
- HALT_OP, 6'd32: opcode that parks the sequencer in HALT.
- CNT_W, 32: width of retired-instruction counter.

- clk  in  1  clock. One clock domain; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- opcode  in  6  inscode[31:26] of the current IR.
- memen, memwr  in  1 each  control-unit memory fields.
- wrreg  in  2  0 = no writeback; nonzero = writeback needed.
- br  in  3  0 none, 1 always, 2 if N, 3 if !N, 4 if Z.
- st  in  3  0 none, 1 SP load, 2 pop, 3 push, 4 return (pop into PC).
- flag_z, flag_n  in  1 each  ALU flags, valid in EXEC.
- mem_ready  in  1  memory completes the access this cycle.
- ir_we, pc_we, pc_src  out  1 each  pc_src 0 = PC+1, 1 = branch target / MDR.
- mem_req, mem_we  out  1 each  memory strobe and write qualifier.
- mdr_we, alu_we, rf_we, sp_we, sp_dec  out  1 each  sp_dec: 1 = SP-1, 0 = SP+1.
- halted  out  1.
- retired  out  CNT_W  instructions completed since reset.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Encoding: one-hot or binary, implementer's choice.
- FETCH: mem_req=1, mem_we=0. Hold until mem_ready. On ready: ir_we=1, pc_we=1, pc_src=0, then go to DECODE.
- DECODE:
  - opcode==HALT_OP: go to HALT and increment retired.
  - st==1: sp_we=1, sp_dec=0 for load (SP<=ALU), then go to FETCH and retire.
  - st==3 (push): sp_we=1, sp_dec=1 (pre-decrement), then go to EXEC.
  - Otherwise: go to EXEC.
- EXEC:
  - alu_we=1.
  - br!=0: taken = (br==1) | (br==2 & flag_n) | (br==3 & !flag_n) | (br==4 & flag_z). If taken: pc_we=1, pc_src=1. Then go to FETCH and retire.
  - memen=1: go to MEM.
  - wrreg!=0: go to WB.
  - Otherwise: go to FETCH and retire.
- MEM: mem_req=1, mem_we=memwr. Hold until mem_ready.
  - On ready with memwr=0: mdr_we=1.
  - Then go to WB if (!memwr & (wrreg!=0 | st==4)). Otherwise go to FETCH and retire.
- WB:
  - rf_we = (wrreg!=0).
  - st==2|4: sp_we=1, sp_dec=0 (post-increment).
  - st==4: pc_we=1, pc_src=1.
  - Then go to FETCH and retire.
- HALT: all strobes 0, halted=1. Only rst exits.
- retired wraps modulo 2^CNT_W.

## Timing
- All outputs are Moore/Mealy combinational from state and registered inputs, asserted only in their listed state. Every strobe is 0 in all other states.
- Reset: state=FETCH, retired=0, halted=0, all strobes 0 in the cycle after rst sample. rst mid-MEM abandons the access; mem_req drops the next cycle.
- Cycle counts with mem_ready always 1:
  - ALU: 4.
  - Branch: 3.
  - Load: 5.
  - Store: 4.
  - Push: 4.
  - Pop: 5.
  - Return: 5.
  - SP load: 2.
  - Halt: 2 to HALT.
- Each mem_ready=0 cycle in FETCH or MEM adds exactly one cycle. Strobes hold steady while waiting; ir_we/mdr_we fire only on the ready cycle.
- retired increments on the cycle the transition into FETCH (or HALT) is taken, never twice per instruction.
- Decode inputs are sampled in DECODE/EXEC/MEM/WB. They must be stable from ir_we+1 onward.

## Structure
- Shared package (cpu_pkg):
  - State enum.
  - br codes (BR_NONE, BR_ALWAYS, BR_NEG, BR_NNEG, BR_ZERO).
  - st codes (ST_NONE, ST_SPLD, ST_POP, ST_PUSH, ST_RET).
  - HALT_OP default.
- One natural sub-module: branch_eval (combinational br/flags -> taken). Everything else stays in multicycle_sequencer.

## Test plan
- Reset, ALU op: rst high 2 cycles, then opcode=0, wrreg=1, mem_ready=1. Expect FETCH→DECODE→EXEC→WB; rf_we in cycle 4; retired=1 after cycle 4.
- Load with waits: opcode=18, memen=1, wrreg=2, mem_ready low 3 cycles in MEM. Expect mem_req held 4 cycles, mdr_we once, rf_we in WB; total 8 cycles.
- Branches: br=4 with flag_z=1 gives pc_we+pc_src=1 in EXEC. Same with flag_z=0 gives no EXEC pc_we. br=2 with flag_n=1 is taken. Each takes 3 cycles.
- Stack ops:
  - Push (st=3, memwr=1): sp_we/sp_dec=1 in DECODE, mem_we in MEM, no rf_we.
  - Return (st=4): mdr_we in MEM; in WB, pc_we, pc_src=1 and sp_we with sp_dec=0.
- Halt: opcode=32. Expect halted=1 from cycle 3, all strobes 0 for 20 cycles, retired frozen; rst returns to FETCH.
- Reset mid-MEM: assert rst during store wait. Next cycle mem_req=0, mem_we=0, retired=0, state FETCH.
